// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a byte FIFO, a serializer drains it
// LSB first on tx, and a status word reports FIFO/serializer state to CPU loads.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Serializer
    state_e           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic sel_data, sel_stat;
    logic full, empty, busy;
    logic push, pop, ovf_evt, ovf_clr;
    logic baud_wrap;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        sel_data  = (addr == BASE_ADDR);
        sel_stat  = (addr == BASE_ADDR + 32'd4);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        busy      = (state_q != StIdle);
        // Fullness is judged before this edge's pop, so a same-cycle pop never rescues a push.
        push      = we & sel_data & ~full;
        ovf_evt   = we & sel_data & full;
        ovf_clr   = we & sel_stat & wdata[3];
        baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    end

    // Serializer next-state
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[head_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StStop: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                baud_d  = '0;
            end
        endcase

        // tx is driven from the next state so the line is a clean flop output.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO next-state
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            mem_d[tail_q] = wdata[7:0];
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (sel_stat) begin
            rdata = {24'h0, 4'(count_q), ovf_q, busy, empty, full};
        end
        tx  = tx_q;
        irq = empty & ~busy;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDR=0x100.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] STAT = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rst_cnt = 0;

    byte unsigned rx_b[$];
    int           rx_t[$];
    bit           rx_stop[$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    // Line receiver: samples mid-bit on falling clock edges; frames hit by a reset are dropped.
    initial begin : monitor
        byte unsigned b;
        int st;
        int rc;
        bit sb;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                st = cyc;
                rc = rst_cnt;
                b  = 8'h00;
                repeat (6) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    b[j] = tx;
                    repeat (4) @(negedge clk);
                end
                sb = tx;
                if (rst_cnt == rc) begin
                    rx_b.push_back(b);
                    rx_t.push_back(st);
                    rx_stop.push_back(sb);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_stat(output logic [31:0] v);
        @(negedge clk);
        we   = 1'b0;
        addr = STAT;
        #1 v = rdata;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq === 1'b1 && tx === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_rx();
        rx_b.delete();
        rx_t.delete();
        rx_stop.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        addr = STAT;
        #1;
        tests_run++;
        if (tx !== 1'b1) begin
            tests_failed++; $display("FAIL reset_tx: got %b want 1", tx);
        end
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++; $display("FAIL reset_irq: got %b want 1", irq);
        end
        tests_run++;
        if (rdata !== 32'h2) begin
            tests_failed++; $display("FAIL reset_status: got %h want 00000002", rdata);
        end
        addr = BASE;
        #1;
        tests_run++;
        if (rdata !== 32'h0) begin
            tests_failed++; $display("FAIL read_txdata: got %h want 00000000", rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [7:0] data = 8'hA5;
        logic [31:0] v;
        logic exp;
        int bad = 0;
        int bad_i = 0;
        logic bad_v = 1'b0;
        bit ok;
        wait_idle(50, ok);
        clear_rx();
        store(BASE, 32'h1A5);
        read_stat(v);
        tests_run++;
        if (tx !== 1'b1 || v !== 32'h10) begin
            tests_failed++;
            $display("FAIL single_queued: tx=%b status=%h want tx=1 status=00000010", tx, v);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 4) exp = 1'b0;
            else if (i < 36) exp = data[(i - 4) / 4];
            else exp = 1'b1;
            if (tx !== exp && bad == 0) begin
                bad = 1; bad_i = i; bad_v = tx;
            end
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL single_waveform: cycle %0d tx=%b want %b", bad_i, bad_v, !bad_v);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1 || tx !== 1'b1) begin
            tests_failed++; $display("FAIL single_irq: irq=%b tx=%b want 1 1", irq, tx);
        end
        tests_run++;
        if (rx_b.size() != 1 || rx_b[0] !== 8'hA5 || rx_stop[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_rx: %0d frames, first=%h want 1 frame a5", rx_b.size(),
                     (rx_b.size() > 0) ? rx_b[0] : 8'h00);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] v;
        bit ok;
        wait_idle(50, ok);
        clear_rx();
        for (int i = 0; i < 10; i++) store(BASE, 32'h30 + i);
        read_stat(v);
        // count 8, overflow, busy (serializer sending 0x30), full
        tests_run++;
        if (v !== 32'h8D) begin
            tests_failed++; $display("FAIL fill_status: got %h want 0000008d", v);
        end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] v;
        bit ok;
        bit seq_ok = 1'b1;
        store(STAT, 32'h8);
        read_stat(v);
        tests_run++;
        if (v !== 32'h85) begin
            tests_failed++; $display("FAIL ovf_clear_status: got %h want 00000085", v);
        end
        wait_idle(9 * 41 + 60, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL drain_timeout: irq=%b want 1", irq);
        end
        if (rx_b.size() != 9) seq_ok = 1'b0;
        else begin
            for (int i = 0; i < 9; i++) begin
                if (rx_b[i] !== 8'(8'h30 + i) || rx_stop[i] !== 1'b1) seq_ok = 1'b0;
            end
        end
        tests_run++;
        if (!seq_ok) begin
            tests_failed++;
            $display("FAIL drain_bytes: %0d frames, last=%h want 9 frames 30..38", rx_b.size(),
                     (rx_b.size() > 0) ? rx_b[rx_b.size() - 1] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_idle(50, ok);
        clear_rx();
        store(BASE, 32'h55);
        store(BASE, 32'hAA);
        idle_bus();
        wait_idle(150, ok);
        tests_run++;
        if (!ok || rx_b.size() != 2 || rx_b[0] !== 8'h55 || rx_b[1] !== 8'hAA) begin
            tests_failed++;
            $display("FAIL b2b_bytes: %0d frames idle=%b want 55 aa", rx_b.size(), ok);
        end
        tests_run++;
        if (rx_t.size() != 2 || rx_t[1] - rx_t[0] != 41) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d want 41",
                     (rx_t.size() == 2) ? rx_t[1] - rx_t[0] : -1);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        bit ok;
        int lows = 0;
        wait_idle(50, ok);
        clear_rx();
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        store(BASE, 32'h44);
        idle_bus();
        repeat (13) @(negedge clk);
        read_stat(v);
        tests_run++;
        if (v !== 32'h34) begin
            tests_failed++; $display("FAIL pre_reset_status: got %h want 00000034", v);
        end
        rst = 1'b1;
        read_stat(v);
        tests_run++;
        if (tx !== 1'b1 || irq !== 1'b1 || v !== 32'h2) begin
            tests_failed++;
            $display("FAIL mid_reset: tx=%b irq=%b status=%h want 1 1 00000002", tx, irq, v);
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        store(32'h108, 32'h77);
        read_stat(v);
        tests_run++;
        if (v !== 32'h2) begin
            tests_failed++; $display("FAIL stray_store_status: got %h want 00000002", v);
        end
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0 || rx_b.size() != 0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: %0d low cycles %0d frames want 0 0", lows,
                     rx_b.size());
        end
        store(BASE, 32'h5A);
        idle_bus();
        wait_idle(100, ok);
        tests_run++;
        if (!ok || rx_b.size() != 1 || rx_b[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL post_reset_tx: %0d frames idle=%b want one frame 5a", rx_b.size(),
                     ok);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_overflow_clear();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
